// File: rtl/alu_ctrl_mem_unit.sv
// Execution/memory slice for the 16-bit RISC core: registered ALU with compare flags,
// registered instruction decoder and a single-port synchronous data memory.
module alu_ctrl_mem_unit #(
  parameter int DATA_W = 16,
  parameter int MEM_AW = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic [2:0]          opcode,
  input  logic                mode,
  output logic [2*DATA_W-1:0] out_alu,
  output logic                za,
  output logic                zb,
  output logic                eq,
  output logic                gt,
  output logic                lt,
  input  logic [DATA_W-1:0]   instruction,
  output logic [2:0]          control_signals,
  input  logic [DATA_W-1:0]   mem_addr,
  input  logic [DATA_W-1:0]   mem_data_in,
  input  logic                mem_we,
  output logic [DATA_W-1:0]   mem_data_out
);

  localparam int ResW = 2 * DATA_W;
  localparam int PadW = ResW - DATA_W - 1;

  typedef enum logic [2:0] {
    OpAdd = 3'b000, OpSub = 3'b001, OpAnd = 3'b010, OpOr  = 3'b011,
    OpXor = 3'b100, OpNot = 3'b101, OpShl = 3'b110, OpShr = 3'b111
  } baseOp_e;

  typedef enum logic [2:0] {
    OpMul  = 3'b000, OpInc = 3'b001, OpDec  = 3'b010, OpNeg  = 3'b011,
    OpNand = 3'b100, OpNor = 3'b101, OpXnor = 3'b110, OpPass = 3'b111
  } extOp_e;

  // 17-bit arithmetic intermediates; bit DATA_W is the carry or the sign.
  logic [DATA_W:0] sumAb, diffAb, incA, decA, negA;
  assign sumAb  = {1'b0, a} + {1'b0, b};
  assign diffAb = {1'b0, a} - {1'b0, b};
  assign incA   = {1'b0, a} + 1'b1;
  assign decA   = {1'b0, a} - 1'b1;
  assign negA   = '0 - {1'b0, a};

  logic [ResW-1:0] aluNext;
  logic [ResW-1:0] aWide, bWide;
  assign aWide = {{DATA_W{1'b0}}, a};
  assign bWide = {{DATA_W{1'b0}}, b};

  always_comb begin
    // NOTE: default assigned first so no path through the case leaves aluNext unassigned (no latch).
    aluNext = '0;
    if (!mode) begin
      unique case (baseOp_e'(opcode))
        OpAdd: aluNext = {{PadW{1'b0}}, sumAb};
        OpSub: aluNext = {{PadW{diffAb[DATA_W]}}, diffAb};
        OpAnd: aluNext = aWide & bWide;
        OpOr:  aluNext = aWide | bWide;
        OpXor: aluNext = aWide ^ bWide;
        OpNot: aluNext = {{DATA_W{1'b0}}, ~a};
        OpShl: aluNext = aWide << b[3:0];
        OpShr: aluNext = aWide >> b[3:0];
      endcase
    end else begin
      unique case (extOp_e'(opcode))
        OpMul:  aluNext = aWide * bWide;
        OpInc:  aluNext = {{PadW{1'b0}}, incA};
        OpDec:  aluNext = {{PadW{decA[DATA_W]}}, decA};
        OpNeg:  aluNext = {{PadW{negA[DATA_W]}}, negA};
        OpNand: aluNext = {{DATA_W{1'b0}}, ~(a & b)};
        OpNor:  aluNext = {{DATA_W{1'b0}}, ~(a | b)};
        OpXnor: aluNext = {{DATA_W{1'b0}}, ~(a ^ b)};
        OpPass: aluNext = aWide;
      endcase
    end
  end

  // Decoder: only the low nibble selects the instruction class.
  logic [2:0] ctrlNext;
  always_comb begin
    ctrlNext = 3'b000;
    unique case (instruction[3:0]) inside
      4'h1:         ctrlNext = 3'b101;
      4'h2:         ctrlNext = 3'b010;
      [4'h3:4'hB]:  ctrlNext = 3'b100;
      default:      ctrlNext = 3'b000;
    endcase
  end

  logic [DATA_W-1:0] mem [2**MEM_AW];
  logic [MEM_AW-1:0] memIdx;
  assign memIdx = mem_addr[MEM_AW-1:0];

  // NOTE: the array has no reset branch; clearing 256 words is not required and keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[memIdx] <= mem_data_in;
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_alu         <= '0;
      {za, zb, eq, gt, lt} <= '0;
      control_signals <= '0;
      mem_data_out    <= '0;
    end else begin
      out_alu         <= aluNext;
      za              <= (a == '0);
      zb              <= (b == '0);
      eq              <= (a == b);
      gt              <= (a > b);
      lt              <= (a < b);
      control_signals <= ctrlNext;
      // Write-first: a same-cycle write is forwarded to the read port.
      mem_data_out    <= mem_we ? mem_data_in : mem[memIdx];
    end
  end

endmodule

// File: tb/tb_alu_ctrl_mem_unit.sv
// Directed self-checking bench for alu_ctrl_mem_unit: ALU ops and flags, decoder map,
// memory write/read/wrap, read-during-write and reset interactions.
module tb_alu_ctrl_mem_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a, b;
  logic [2:0]  opcode;
  logic        mode;
  logic [31:0] out_alu;
  logic        za, zb, eq, gt, lt;
  logic [15:0] instruction;
  logic [2:0]  control_signals;
  logic [15:0] mem_addr, mem_data_in, mem_data_out;
  logic        mem_we;

  int checkCount = 0;
  int passCount  = 0;

  alu_ctrl_mem_unit dut (
    .clk(clk), .reset(reset), .a(a), .b(b), .opcode(opcode), .mode(mode),
    .out_alu(out_alu), .za(za), .zb(zb), .eq(eq), .gt(gt), .lt(lt),
    .instruction(instruction), .control_signals(control_signals),
    .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_we(mem_we),
    .mem_data_out(mem_data_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    else passCount++;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        m;
    logic [2:0]  op;
    logic [15:0] va, vb;
    logic [31:0] res;
    logic [4:0]  flg;   // {za, zb, eq, gt, lt}
  } aluVec_t;

  typedef struct {
    logic [15:0] ins;
    logic [2:0]  ctl;
  } decVec_t;

  aluVec_t aluQ[$];
  decVec_t decQ[$];

  initial begin
    aluQ.push_back('{1'b0, 3'b000, 16'h0001, 16'h0010, 32'h0000_0011, 5'b00001});
    aluQ.push_back('{1'b0, 3'b001, 16'h0001, 16'h0010, 32'hFFFF_FFF1, 5'b00001});
    aluQ.push_back('{1'b0, 3'b010, 16'h0001, 16'h0010, 32'h0000_0000, 5'b00001});
    aluQ.push_back('{1'b0, 3'b011, 16'h0001, 16'h0010, 32'h0000_0011, 5'b00001});
    aluQ.push_back('{1'b0, 3'b100, 16'h0001, 16'h0010, 32'h0000_0011, 5'b00001});
    aluQ.push_back('{1'b0, 3'b101, 16'h0001, 16'h0010, 32'h0000_FFFE, 5'b00001});
    aluQ.push_back('{1'b0, 3'b110, 16'h8001, 16'h0004, 32'h0008_0010, 5'b00010});
    aluQ.push_back('{1'b0, 3'b111, 16'h8001, 16'h0004, 32'h0000_0800, 5'b00010});
    aluQ.push_back('{1'b1, 3'b000, 16'h0001, 16'h0010, 32'h0000_0010, 5'b00001});
    aluQ.push_back('{1'b1, 3'b001, 16'hFFFF, 16'h0010, 32'h0001_0000, 5'b00010});
    aluQ.push_back('{1'b1, 3'b010, 16'h0000, 16'h0010, 32'hFFFF_FFFF, 5'b10001});
    aluQ.push_back('{1'b1, 3'b011, 16'h0001, 16'h0010, 32'hFFFF_FFFF, 5'b00001});
    aluQ.push_back('{1'b1, 3'b100, 16'h0001, 16'h0010, 32'h0000_FFFF, 5'b00001});
    aluQ.push_back('{1'b1, 3'b101, 16'h0001, 16'h0010, 32'h0000_FFEE, 5'b00001});
    aluQ.push_back('{1'b1, 3'b110, 16'h0001, 16'h0010, 32'h0000_FFEE, 5'b00001});
    aluQ.push_back('{1'b1, 3'b111, 16'h1234, 16'h0010, 32'h0000_1234, 5'b00010});
    aluQ.push_back('{1'b0, 3'b000, 16'hFFFF, 16'hFFFF, 32'h0001_FFFE, 5'b00100});
    aluQ.push_back('{1'b1, 3'b000, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 5'b00100});
    aluQ.push_back('{1'b0, 3'b000, 16'h0000, 16'h0000, 32'h0000_0000, 5'b11100});

    decQ.push_back('{16'h0001, 3'b101});
    decQ.push_back('{16'h0002, 3'b010});
    decQ.push_back('{16'h0005, 3'b100});
    decQ.push_back('{16'h000B, 3'b100});
    decQ.push_back('{16'h000C, 3'b000});
    decQ.push_back('{16'h000F, 3'b000});
    decQ.push_back('{16'h0000, 3'b000});
    decQ.push_back('{16'hF001, 3'b101});

    reset = 1'b1; a = '0; b = '0; opcode = '0; mode = 1'b0;
    instruction = '0; mem_addr = '0; mem_data_in = '0; mem_we = 1'b0;
    step();
    step();
    check("rst_alu",   out_alu, 32'h0);
    check("rst_flags", {27'h0, za, zb, eq, gt, lt}, 32'h0);
    check("rst_ctrl",  {29'h0, control_signals}, 32'h0);
    check("rst_mem",   {16'h0, mem_data_out}, 32'h0);

    reset = 1'b0;
    foreach (aluQ[i]) begin
      mode = aluQ[i].m; opcode = aluQ[i].op; a = aluQ[i].va; b = aluQ[i].vb;
      step();
      check($sformatf("alu%0d_m%0d_op%0d", i, aluQ[i].m, aluQ[i].op), out_alu, aluQ[i].res);
      check($sformatf("flags%0d", i), {27'h0, za, zb, eq, gt, lt}, {27'h0, aluQ[i].flg});
    end

    foreach (decQ[i]) begin
      instruction = decQ[i].ins;
      step();
      check($sformatf("dec_%04h", decQ[i].ins), {29'h0, control_signals}, {29'h0, decQ[i].ctl});
    end

    mem_we = 1'b1; mem_addr = 16'h0001; mem_data_in = 16'hABCD;
    step();
    mem_we = 1'b0; mem_data_in = 16'h0000;
    step();
    check("mem_rd_1", {16'h0, mem_data_out}, 32'h0000_ABCD);
    mem_addr = 16'h0101;
    step();
    check("mem_wrap_101", {16'h0, mem_data_out}, 32'h0000_ABCD);

    mem_we = 1'b1; mem_addr = 16'h0001; mem_data_in = 16'h1234;
    step();
    check("mem_rdw", {16'h0, mem_data_out}, 32'h0000_1234);

    mem_we = 1'b0; mode = 1'b0; opcode = 3'b000; a = 16'h0003; b = 16'h0004;
    instruction = 16'h0001;
    step();
    check("pre_rst_alu",  out_alu, 32'h0000_0007);
    check("pre_rst_ctrl", {29'h0, control_signals}, 32'h5);

    reset = 1'b1; mem_we = 1'b1; mem_data_in = 16'h5555;
    step();
    check("mid_rst_alu",   out_alu, 32'h0);
    check("mid_rst_flags", {27'h0, za, zb, eq, gt, lt}, 32'h0);
    check("mid_rst_ctrl",  {29'h0, control_signals}, 32'h0);
    check("mid_rst_mem",   {16'h0, mem_data_out}, 32'h0);

    reset = 1'b0; mem_we = 1'b0;
    step();
    check("resume_alu",   out_alu, 32'h0000_0007);
    check("resume_flags", {27'h0, za, zb, eq, gt, lt}, 32'h1);
    check("resume_ctrl",  {29'h0, control_signals}, 32'h5);
    check("resume_mem_kept", {16'h0, mem_data_out}, 32'h0000_1234);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
